sram_responder: RTL and testbench

- Memory-side responder for the LC-3 datapath's SRAM strobe interface.
- Services the active-low CE/OE/WE/UB/LB cycles issued by the control unit's fetch, load and store states.
- Backs them with an on-chip word array, at fixed read/write latencies that match the control unit's two-cycle memory states.
- Sits between the datapath's MAR/MDR and on-chip block RAM; replaces the external SRAM in simulation and in on-chip builds.

---
 rtl/sram_responder_pkg.sv | 31 +++
 rtl/sram_resp_array.sv | 27 ++
 rtl/sram_responder.sv | 163 ++++++++++++++++
 tb/tb_sram_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_responder_pkg.sv
// Shared types and constants for the SRAM strobe responder.
// INIT_WORDS/INIT_IMAGE are consumed only when SRAM_RESPONDER_INIT_EN is defined.
package sram_responder_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_WR_WAIT,
    ST_WR_DONE,
    ST_INIT
  } state_t;

  localparam int INIT_WORDS = 4;
  localparam int INIT_LAST  = (INIT_WORDS > 0) ? INIT_WORDS - 1 : 0;
  localparam int INIT_IDX_W = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;

  localparam logic [DATA_W-1:0] INIT_IMAGE [0:INIT_LAST] = '{
    16'h3000, 16'h5020, 16'h1261, 16'hF025
  };

  // Strobes are active low: a high lane strobe zeroes that byte.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] d,
                                                  input logic ub_n,
                                                  input logic lb_n);
    return {ub_n ? 8'h00 : d[15:8], lb_n ? 8'h00 : d[7:0]};
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// DEPTH x 16 word store: registered read port, one byte-enabled write port.
module sram_resp_array
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              i_we,
  input  logic [1:0]        i_be,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // NOTE: the storage array has no reset so it maps onto block RAM; contents persist across Reset.
  always_ff @(posedge Clk) begin
    if (i_we) begin
      if (i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
      if (i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sram_responder.sv
// LC-3 SRAM strobe responder: active-low CE/OE/WE/UB/LB cycles served from on-chip RAM.
// Define SRAM_RESPONDER_INIT_EN to preload INIT_IMAGE after reset while Busy is high.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Data_Valid,
  output logic              Busy
);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic [3:0]        w_cnt_next;
  logic              w_rd_req, w_wr_req, w_wr_open, w_rd_fire, w_wr_fire;
  logic              w_init, w_init_last;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;
  logic              w_arr_we;
  logic [1:0]        w_arr_be;
  logic [ADDR_W-1:0] w_arr_waddr, w_arr_raddr;
  logic [DATA_W-1:0] w_arr_wdata, w_arr_rdata;

  assign w_cnt_next = {1'b0, r_cnt} + 4'd1;
  assign w_wr_req   = ~Mem_CE & ~Mem_WE;
  assign w_rd_req   = ~Mem_CE & ~Mem_OE & Mem_WE;

  // A write episode opens from IDLE or by pre-empting a read; WRITE_LAT=1 commits on that first sample.
  assign w_wr_open = (r_state == ST_IDLE) || (r_state == ST_RD_WAIT) || (r_state == ST_RD_HOLD);
  assign w_wr_fire = ~Reset & w_wr_req &
                     (w_wr_open ? (WRITE_LAT == 1)
                                : ((r_state == ST_WR_WAIT) && (w_cnt_next == 4'(WRITE_LAT))));
  assign w_rd_fire = w_rd_req && (r_state == ST_RD_WAIT) && (w_cnt_next == 4'(READ_LAT));

`ifdef SRAM_RESPONDER_INIT_EN
  localparam state_t RESET_STATE = (INIT_WORDS > 0) ? ST_INIT : ST_IDLE;

  logic [INIT_IDX_W-1:0] r_init_idx;
  logic                  r_busy;

  assign w_init      = (r_state == ST_INIT);
  assign w_init_last = (r_init_idx == INIT_IDX_W'(INIT_LAST));
  assign w_init_addr = ADDR_W'(r_init_idx);
  assign w_init_data = INIT_IMAGE[r_init_idx];
  assign Busy        = r_busy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_init_idx <= '0;
      r_busy     <= (INIT_WORDS > 0);
    end else if (w_init) begin
      r_init_idx <= r_init_idx + 1'b1;
      if (w_init_last) r_busy <= 1'b0;
    end
  end
`else
  localparam state_t RESET_STATE = ST_IDLE;

  assign w_init      = 1'b0;
  assign w_init_last = 1'b1;
  assign w_init_addr = '0;
  assign w_init_data = '0;
  assign Busy        = 1'b0;
`endif

  assign w_arr_we    = w_init ? ~Reset : w_wr_fire;
  assign w_arr_be    = w_init ? 2'b11 : ~{Mem_UB, Mem_LB};
  assign w_arr_waddr = w_init ? w_init_addr : ((r_state == ST_WR_WAIT) ? r_addr : ADDR);
  assign w_arr_wdata = w_init ? w_init_data : Data_to_SRAM;
  // Reading ADDR directly in IDLE gives the registered RAM port a cycle's head start.
  assign w_arr_raddr = (r_state == ST_IDLE) ? ADDR : r_addr;

  sram_resp_array #(.ADDR_W(ADDR_W)) u_array (
    .Clk     (Clk),
    .i_we    (w_arr_we),
    .i_be    (w_arr_be),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_raddr (w_arr_raddr),
    .o_rdata (w_arr_rdata)
  );

  // NOTE: every register here is assigned with <= so all branches see pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= RESET_STATE;
      r_cnt          <= '0;
      r_addr         <= '0;
      Data_from_SRAM <= '0;
      Data_Valid     <= 1'b0;
    end else if (w_init) begin
      if (w_init_last) r_state <= ST_IDLE;
    end else if (Mem_CE) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      Data_Valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!Mem_WE) begin
            r_addr  <= ADDR;
            r_cnt   <= 3'd1;
            r_state <= (WRITE_LAT == 1) ? ST_WR_DONE : ST_WR_WAIT;
          end else if (!Mem_OE) begin
            r_addr  <= ADDR;
            r_cnt   <= 3'd1;
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT, ST_RD_HOLD: begin
          if (!Mem_WE) begin
            Data_Valid <= 1'b0;
            r_addr     <= ADDR;
            r_cnt      <= 3'd1;
            r_state    <= (WRITE_LAT == 1) ? ST_WR_DONE : ST_WR_WAIT;
          end else if (Mem_OE) begin
            Data_Valid <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
          end else if (r_state == ST_RD_WAIT) begin
            r_cnt <= w_cnt_next[2:0];
            if (w_rd_fire) begin
              Data_from_SRAM <= lane_mask(w_arr_rdata, Mem_UB, Mem_LB);
              Data_Valid     <= 1'b1;
              r_state        <= ST_RD_HOLD;
            end
          end
        end
        ST_WR_WAIT: begin
          if (Mem_WE) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= w_cnt_next[2:0];
            if (w_wr_fire) r_state <= ST_WR_DONE;
          end
        end
        ST_WR_DONE: begin
          if (Mem_WE) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Randomized self-checking bench for sram_responder against a word-array reference model.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 2;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1;
  logic              Mem_UB = 1'b1, Mem_LB = 1'b1;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [15:0]       Data_to_SRAM = '0;
  logic [15:0]       Data_from_SRAM;
  logic              Data_Valid, Busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: one 16-bit word per address, updated whenever a write episode is long enough to commit.
  logic [15:0] model_mem [1024];
  logic [ADDR_W-1:0] pool [8];

  sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Mem_CE         (Mem_CE),
    .Mem_OE         (Mem_OE),
    .Mem_WE         (Mem_WE),
    .Mem_UB         (Mem_UB),
    .Mem_LB         (Mem_LB),
    .ADDR           (ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .Data_Valid     (Data_Valid),
    .Busy           (Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required bench to finish first");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] expect_lanes(input logic [15:0] d, input logic ub_n, input logic lb_n);
    logic [15:0] keep;
    keep = {{8{~ub_n}}, {8{~lb_n}}};
    return d & keep;
  endfunction

  // WE held low for n samples; the data bus switches to d_late after the commit sample.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] a_later,
                          input logic [15:0] d, input logic [15:0] d_late,
                          input logic ub_n, input logic lb_n, input int n);
    Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0;
    Mem_UB = ub_n; Mem_LB = lb_n; ADDR = a; Data_to_SRAM = d;
    for (int k = 1; k <= n; k++) begin
      tick();
      ADDR = a_later;
      if (k == WRITE_LAT) Data_to_SRAM = d_late;
      check("wr_valid", 16'(Data_Valid), 16'h0);
    end
    Mem_WE = 1'b1;
    tick();
    if (n >= WRITE_LAT) begin
      if (!ub_n) model_mem[a][15:8] = d[15:8];
      if (!lb_n) model_mem[a][7:0]  = d[7:0];
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] a_later,
                         input logic ub_n, input logic lb_n, input int n);
    logic [15:0] exp;
    exp = expect_lanes(model_mem[a], ub_n, lb_n);
    Mem_CE = 1'b0; Mem_WE = 1'b1; Mem_OE = 1'b0;
    Mem_UB = ub_n; Mem_LB = lb_n; ADDR = a;
    for (int k = 1; k <= n; k++) begin
      tick();
      ADDR = a_later;
      check("rd_valid", 16'(Data_Valid), 16'(k >= READ_LAT));
      if (k >= READ_LAT) check("rd_data", Data_from_SRAM, exp);
    end
    Mem_OE = 1'b1;
    tick();
    check("rd_end_valid", 16'(Data_Valid), 16'h0);
    if (n >= READ_LAT) check("rd_hold_data", Data_from_SRAM, exp);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_data", Data_from_SRAM, 16'h0000);
    check("rst_valid", 16'(Data_Valid), 16'h0);
`ifdef SRAM_RESPONDER_INIT_EN
    check("rst_busy", 16'(Busy), 16'(INIT_WORDS > 0));
    Reset = 1'b0;
    // A write attempted while Busy must be ignored.
    Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = '0; Data_to_SRAM = 16'hDEAD;
    Mem_UB = 1'b0; Mem_LB = 1'b0;
    for (int k = 1; k <= INIT_WORDS; k++) begin
      tick();
      check("init_busy", 16'(Busy), 16'(k < INIT_WORDS));
    end
    Mem_WE = 1'b1; Mem_CE = 1'b1;
    tick();
    for (int i = 0; i < INIT_WORDS; i++) model_mem[i] = INIT_IMAGE[i];
    for (int i = 0; i < INIT_WORDS; i++) do_read(ADDR_W'(i), ADDR_W'(i), 1'b0, 1'b0, 2);
`else
    check("rst_busy", 16'(Busy), 16'h0);
    Reset = 1'b0;
    Mem_CE = 1'b0;
    tick();
    check("idle_busy", 16'(Busy), 16'h0);
`endif

    // Write then read back
    do_write(10'h005, 10'h005, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 2);
    do_read(10'h005, 10'h005, 1'b0, 1'b0, 2);

    // Byte lanes
    do_write(10'h010, 10'h010, 16'h1234, 16'h1234, 1'b0, 1'b0, 2);
    do_write(10'h010, 10'h010, 16'hABCD, 16'hABCD, 1'b1, 1'b0, 2);
    do_read(10'h010, 10'h010, 1'b0, 1'b0, 2);
    check("lane_merge", model_mem[10'h010], 16'h12CD);
    do_read(10'h010, 10'h010, 1'b0, 1'b1, 3);

    // Aborted write, then a long write that must commit only once
    do_write(10'h020, 10'h020, 16'h0001, 16'h0001, 1'b0, 1'b0, 2);
    do_write(10'h020, 10'h020, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1);
    do_read(10'h020, 10'h020, 1'b0, 1'b0, 2);
    do_write(10'h020, 10'h021, 16'h5A5A, 16'h0F0F, 1'b0, 1'b0, 5);
    do_read(10'h020, 10'h020, 1'b0, 1'b0, 2);

    // Address changes during a read are ignored
    do_write(10'h030, 10'h030, 16'h0A0A, 16'h0A0A, 1'b0, 1'b0, 2);
    do_write(10'h031, 10'h031, 16'h5555, 16'h5555, 1'b0, 1'b0, 2);
    do_read(10'h030, 10'h031, 1'b0, 1'b0, 4);

    // CE drop mid-read
    do_write(10'h040, 10'h040, 16'h1111, 16'h1111, 1'b0, 1'b0, 2);
    Mem_CE = 1'b0; Mem_WE = 1'b1; Mem_OE = 1'b0; ADDR = 10'h040;
    tick();
    tick();
    check("ce_pre_valid", 16'(Data_Valid), 16'h1);
    Mem_CE = 1'b1;
    tick();
    check("ce_drop_valid", 16'(Data_Valid), 16'h0);
    check("ce_drop_data", Data_from_SRAM, 16'h1111);
    Mem_CE = 1'b0; Mem_OE = 1'b1;
    tick();

    // WE falling during a read pre-empts it and re-latches the address
    do_write(10'h050, 10'h050, 16'h7777, 16'h7777, 1'b0, 1'b0, 2);
    Mem_OE = 1'b0; ADDR = 10'h050;
    tick();
    tick();
    check("sw_pre_valid", 16'(Data_Valid), 16'h1);
    Mem_WE = 1'b0; ADDR = 10'h051; Data_to_SRAM = 16'h4242;
    tick();
    check("sw_abort_valid", 16'(Data_Valid), 16'h0);
    ADDR = 10'h050;
    tick();
    Mem_WE = 1'b1; Mem_OE = 1'b1;
    tick();
    model_mem[10'h051] = 16'h4242;
    do_read(10'h051, 10'h051, 1'b0, 1'b0, 2);
    do_read(10'h050, 10'h050, 1'b0, 1'b0, 2);

    // Reset while a write is pending
    do_write(10'h060, 10'h060, 16'h1111, 16'h1111, 1'b0, 1'b0, 2);
    Mem_WE = 1'b0; ADDR = 10'h060; Data_to_SRAM = 16'h2222;
    tick();
    Reset = 1'b1;
    tick();
    check("rst_wr_data", Data_from_SRAM, 16'h0000);
    check("rst_wr_valid", 16'(Data_Valid), 16'h0);
    Reset = 1'b0; Mem_WE = 1'b1;
    tick();
`ifdef SRAM_RESPONDER_INIT_EN
    for (int k = 1; k < INIT_WORDS; k++) tick();
    for (int i = 0; i < INIT_WORDS; i++) model_mem[i] = INIT_IMAGE[i];
`endif
    do_read(10'h060, 10'h060, 1'b0, 1'b0, 2);

    // Randomized traffic over a small address pool
    for (int i = 0; i < 8; i++) begin
      pool[i] = ADDR_W'($urandom_range(10'h100, 10'h3FF));
      do_write(pool[i], pool[i], 16'($urandom), 16'($urandom), 1'b0, 1'b0, 2);
    end
    for (int i = 0; i < 200; i++) begin
      logic [ADDR_W-1:0] a;
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0)
        do_write(a, ADDR_W'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(1, 5));
      else
        do_read(a, ADDR_W'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
